// File: rtl/jtopl_timer_pkg.sv
// Shared constants for the OPL timer A/B controller: register map, control
// and status bit positions, and the status byte layout.
package jtopl_timer_pkg;

    localparam int unsigned DW = 8;

    localparam logic [DW-1:0] ADDR_TA_DEF  = 8'h02;
    localparam logic [DW-1:0] ADDR_TB_DEF  = 8'h03;
    localparam logic [DW-1:0] ADDR_CTL_DEF = 8'h04;

    localparam int unsigned CTL_IRQRST = 7;
    localparam int unsigned CTL_MASKA  = 6;
    localparam int unsigned CTL_MASKB  = 5;
    localparam int unsigned CTL_STB    = 1;
    localparam int unsigned CTL_STA    = 0;

    localparam int unsigned ST_IRQ   = 7;
    localparam int unsigned ST_FLAGA = 6;
    localparam int unsigned ST_FLAGB = 5;

    typedef struct packed {
        logic       irq;
        logic       flag_a;
        logic       flag_b;
        logic [4:0] rsvd;
    } status_t;

    function automatic status_t make_status(input logic fa, input logic fb);
        status_t s;
        s.irq    = fa | fb;
        s.flag_a = fa;
        s.flag_b = fb;
        s.rsvd   = '0;
        return s;
    endfunction

endpackage

// File: rtl/jtopl_timer_cnt.sv
// One reloadable 8-bit timer with optional tick prescaler and overflow flag.
// ovf_c is the flag-raising event of this cycle (overflow not masked).
module jtopl_timer_cnt
    import jtopl_timer_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          st_we,
    input  logic          st_d,
    input  logic [DW-1:0] preload,
    input  logic          tick,
    input  logic          mask,
    input  logic          clr,
    output logic          flag,
    output logic          ovf_c
);

    logic          st;
    logic [DW-1:0] cnt;
    logic          load_c;
    logic          adv_c;
    logic          step_c;

    // A start edge reloads the counter and swallows a coincident tick
    assign load_c = st_we & st_d & ~st;
    assign adv_c  = st & tick & ~load_c;

    generate
        if (DIV == 1) begin : g_nopsc
            assign step_c = adv_c;
        end else begin : g_psc
            localparam int unsigned PW = $clog2(DIV);
            logic [PW-1:0] psc;

            // DIV is a power of two, so the prescaler wraps naturally
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    psc <= '0;
                end else if (load_c) begin
                    psc <= '0;
                end else if (adv_c) begin
                    psc <= psc + PW'(1);
                end
            end

            assign step_c = adv_c & (psc == PW'(DIV - 1));
        end
    endgenerate

    assign ovf_c = step_c & (cnt == 8'hFF) & ~mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= 1'b0;
            cnt  <= '0;
            flag <= 1'b0;
        end else begin
            if (st_we) begin
                st <= st_d;
            end
            if (load_c) begin
                cnt <= preload;
            end else if (step_c) begin
                cnt <= (cnt == 8'hFF) ? preload : cnt + 8'd1;
            end
            flag <= ovf_c | (flag & ~clr);
        end
    end

endmodule

// File: rtl/jtopl_timer_ctl.sv
// Timer A/B controller: register decode, two timer instances, flag/IRQ
// combine and the registered status byte.
module jtopl_timer_ctl
    import jtopl_timer_pkg::*;
#(
    parameter int unsigned    TB_DIV   = 4,
    parameter logic [DW-1:0]  ADDR_TA  = ADDR_TA_DEF,
    parameter logic [DW-1:0]  ADDR_TB  = ADDR_TB_DEF,
    parameter logic [DW-1:0]  ADDR_CTL = ADDR_CTL_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          wr,
    input  logic [DW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic          flag_a,
    output logic          flag_b,
    output logic [DW-1:0] status,
    output logic          irq_n
);

    logic [DW-1:0] ta;
    logic [DW-1:0] tb;
    logic          mask_a;
    logic          mask_b;
    status_t       status_r;

    logic wr_ctl_c;
    logic irq_rst_c;
    logic cfg_c;
    logic mask_a_c;
    logic mask_b_c;
    logic clr_a_c;
    logic clr_b_c;
    logic ovf_a_c;
    logic ovf_b_c;
    logic fa_nxt_c;
    logic fb_nxt_c;

    assign wr_ctl_c  = wr & (addr == ADDR_CTL);
    assign irq_rst_c = wr_ctl_c & din[CTL_IRQRST];
    assign cfg_c     = wr_ctl_c & ~din[CTL_IRQRST];

    // A mask written this cycle already suppresses a coincident overflow
    assign mask_a_c = cfg_c ? din[CTL_MASKA] : mask_a;
    assign mask_b_c = cfg_c ? din[CTL_MASKB] : mask_b;
    assign clr_a_c  = irq_rst_c | (cfg_c & din[CTL_MASKA]);
    assign clr_b_c  = irq_rst_c | (cfg_c & din[CTL_MASKB]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ta     <= '0;
            tb     <= '0;
            mask_a <= 1'b0;
            mask_b <= 1'b0;
        end else begin
            if (wr && addr == ADDR_TA) begin
                ta <= din;
            end
            if (wr && addr == ADDR_TB) begin
                tb <= din;
            end
            if (cfg_c) begin
                mask_a <= din[CTL_MASKA];
                mask_b <= din[CTL_MASKB];
            end
        end
    end

    jtopl_timer_cnt #(.DIV(1)) u_timer_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .st_we   (cfg_c),
        .st_d    (din[CTL_STA]),
        .preload (ta),
        .tick    (tick),
        .mask    (mask_a_c),
        .clr     (clr_a_c),
        .flag    (flag_a),
        .ovf_c   (ovf_a_c)
    );

    jtopl_timer_cnt #(.DIV(TB_DIV)) u_timer_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .st_we   (cfg_c),
        .st_d    (din[CTL_STB]),
        .preload (tb),
        .tick    (tick),
        .mask    (mask_b_c),
        .clr     (clr_b_c),
        .flag    (flag_b),
        .ovf_c   (ovf_b_c)
    );

    // Next-flag values so irq_n and status land on the same edge as the flags
    assign fa_nxt_c = ovf_a_c | (flag_a & ~clr_a_c);
    assign fb_nxt_c = ovf_b_c | (flag_b & ~clr_b_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_n    <= 1'b1;
            status_r <= '0;
        end else begin
            irq_n    <= ~(fa_nxt_c | fb_nxt_c);
            status_r <= make_status(fa_nxt_c, fb_nxt_c);
        end
    end

    assign status = DW'(status_r);

endmodule
